fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the 8-entry fifo between NREQ write requesters and one reader.
//  Grants the fifo write port round-robin in bursts; muxes the winner's data;
//  drives the fifo wr/rd strobes, gated by the fifo full/empty flags.
//  Sits directly in front of fifo: wr/rd outputs connect to fifo wr/rd inputs.
// PARAMETERS
//  NREQ       2   number of write requesters (2..4)
//  DATA_W     8   data width per requester
//  MAX_BURST  4   max writes per grant before forced rotation (1..15)
// PORTS
//  clk     in   1             clock, all state on rising edge
//  rst     in   1             asynchronous, active-low reset (0 = reset)
//  req     in   NREQ          per-requester write request, level
//  last    in   NREQ          requester's final word; qualifies with its write
//  din     in   NREQ*DATA_W   packed requester data, req i at [i*DATA_W +: DATA_W]
//  rd_req  in   1             consumer read request
//  full    in   1             fifo full flag
//  empty   in   1             fifo empty flag
//  gnt     out  NREQ          one-hot grant, registered
//  wr      out  1             fifo write strobe (to fifo wr)
//  wdata   out  DATA_W        din of current owner
//  rd      out  1             fifo read strobe (to fifo rd)
//  busy    out  1             1 while in BURST state
// BEHAVIOUR
//  Reset (rst=0, immediate): state=IDLE, gnt=0, owner=0, burst_cnt=0,
//   rr_last=NREQ-1 (so req[0] wins first), wr=0, rd=0, busy=0, wdata=0.
//  FSM IDLE: if |req, pick first set req after rr_last (wrapping); at edge
//   gnt<=onehot(pick), owner<=pick, burst_cnt<=0, -> BURST. Grant latency 1 cycle.
//  FSM BURST: wr = req[owner] & ~full (combinational). Each cycle wr=1 ->
//   burst_cnt++. Exit to IDLE (gnt<=0, rr_last<=owner) when any of:
//   req[owner]=0; wr & last[owner]; wr & burst_cnt==MAX_BURST-1.
//  IDLE always costs one cycle between grants (no back-to-back regrant).
//  full=1 in BURST: wr=0, burst_cnt holds, grant held; no timeout.
//  full=1 and rd=1 same cycle: write still blocked (flags taken as-is).
//  rd = rd_req & ~empty, combinational; independent of write arbitration.
//  wdata = din[owner] while busy, else 0.
//  Requests from non-owners during BURST are ignored until IDLE.
//  Owner dropping req mid-burst: that cycle no write, exit to IDLE.
//  Reset asserted mid-burst: all outputs drop immediately; pending words lost.
//  burst_cnt width = $clog2(MAX_BURST+1); never exceeds MAX_BURST-1.
// STRUCTURE
//  fifo_arb_pkg: state enum {IDLE=1'b0, BURST=1'b1}, NREQ/MAX_BURST limits.
//  Sub-module rr_pick (req, rr_last -> pick, valid): combinational
//   round-robin picker; the rest (FSM, counters, mux) stays in this module.
// TESTING (NREQ=2, MAX_BURST=4, fifo depth 8)
//  1 Reset: rst=0 with req=2'b11 -> gnt=0, wr=0, rd=0; rst=1 -> next edge gnt=01.
//  2 req=11 held, full=0 -> gnt 01 for 4 writes, 1 idle cycle, gnt 10 for 4
//    writes, idle, gnt 01; wdata tracks din of owner on every wr.
//  3 req[0] with last on 2nd write -> exactly 2 wr pulses, then IDLE, rr_last=0.
//  4 Fill: single requester 10 writes -> wr stops when full=1, gnt held;
//    rd_req=1 one cycle -> full clears, write resumes, burst_cnt continued.
//  5 rd_req=1 with empty=1 -> rd=0; empty=0 -> rd=1 same cycle.
//  6 rst=0 mid-burst (burst_cnt=2) -> gnt=0, busy=0 at once; after release
//    req=11 -> req[0] granted first.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and parameter limits for the fifo write arbiter.
package fifo_arb_pkg;

  // Arbiter FSM: IDLE between grants, BURST while an owner holds the write port.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Legal parameter ranges, enforced at elaboration by the top.
  localparam int NREQ_MIN      = 2;
  localparam int NREQ_MAX      = 4;
  localparam int MAX_BURST_MIN = 1;
  localparam int MAX_BURST_MAX = 15;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after rr_last, wrapping.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_last,
  output logic [IDX_W-1:0] pick,
  output logic             valid
);

  // Scan indices rr_last+1 .. rr_last+NREQ (mod NREQ); the first hit wins.
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_last) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one fifo write port among NREQ requesters,
// plus the reader's gated read strobe.
//
// Handshake: req[i] is a level request. Once gnt[i] is high, every cycle in
// which req[i]=1 and full=0 is a write (wr=1, wdata=din[i]); last[i] is only
// meaningful in a cycle where that write happens. req[i]=0 while granted ends
// the grant with no write that cycle. rd fires whenever rd_req=1 and empty=0.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        last,
  input  logic [NREQ*DATA_W-1:0] din,
  input  logic                   rd_req,
  input  logic                   full,
  input  logic                   empty,
  output logic [NREQ-1:0]        gnt,
  output logic                   wr,
  output logic [DATA_W-1:0]      wdata,
  output logic                   rd,
  output logic                   busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("fifo_wr_arbiter: NREQ out of range");
  end
  if (MAX_BURST < MAX_BURST_MIN || MAX_BURST > MAX_BURST_MAX) begin : g_bad_burst
    $error("fifo_wr_arbiter: MAX_BURST out of range");
  end

  state_e             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [IDX_W-1:0]   rr_last_q, rr_last_d;

  logic [IDX_W-1:0]   pick;
  logic               pick_valid;
  logic               own_req;
  logic               own_last;
  logic [DATA_W-1:0]  own_data;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .rr_last (rr_last_q),
    .pick    (pick),
    .valid   (pick_valid)
  );

  // Select the current owner's request, last flag and data word.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        own_req  = req[i];
        own_last = last[i];
        own_data = din[i*DATA_W +: DATA_W];
      end
    end
  end

  // Fifo strobes and data: writes only while bursting and not full; reads
  // depend only on the reader and the empty flag, and drop during reset.
  always_comb begin
    busy  = (state_q == BURST);
    wr    = busy & own_req & ~full;
    rd    = rst & rd_req & ~empty;
    wdata = busy ? own_data : '0;
    gnt   = gnt_q;
  end

  // Next-state: grant in IDLE, count writes and decide burst end in BURST.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    rr_last_d   = rr_last_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d     = BURST;
          gnt_d       = NREQ'(1) << pick;
          owner_d     = pick;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        if (wr) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
        // Counter is cleared on exit so it never reads MAX_BURST.
        if (!own_req || (wr && own_last) ||
            (wr && (burst_cnt_q == CNT_W'(MAX_BURST - 1)))) begin
          state_d     = IDLE;
          gnt_d       = '0;
          rr_last_d   = owner_q;
          burst_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; rr_last resets to the top index so requester 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      rr_last_q   <= IDX_W'(NREQ - 1);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rr_last_q   <= rr_last_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios followed by random traffic,
// each cycle checked against a transaction-level model of the arbiter and an
// 8-entry fifo occupancy model that drives full/empty.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 2;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int DEPTH     = 8;
  localparam int DW        = NREQ * DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   last;
  logic [DW-1:0]     din;
  logic              rd_req;
  logic              full;
  logic              empty;
  logic [NREQ-1:0]   gnt;
  logic              wr;
  logic [DATA_W-1:0] wdata;
  logic              rd;
  logic              busy;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .last   (last),
    .din    (din),
    .rd_req (rd_req),
    .full   (full),
    .empty  (empty),
    .gnt    (gnt),
    .wr     (wr),
    .wdata  (wdata),
    .rd     (rd),
    .busy   (busy)
  );

  // ---------------- reference model state ----------------
  int   checks = 0;
  int   passed = 0;
  int   occ;        // fifo occupancy
  bit   m_busy;     // a requester currently holds the write port
  int   m_owner;
  int   m_cnt;      // words written in the current grant
  int   m_rr;       // last requester served
  int   wr_seen;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_cnt   = 0;
    m_rr    = NREQ - 1;
  endfunction

  // One clock of arbitration rules: grant next requester after the last one
  // served; a grant ends on request drop, on a last word, or after MAX_BURST words.
  function automatic void model_advance(input logic wrote);
    if (!m_busy) begin
      if (|req) begin
        for (int k = 1; k <= NREQ; k++) begin
          int i;
          i = (m_rr + k) % NREQ;
          if (req[i]) begin
            m_owner = i;
            break;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (!req[m_owner]) begin
      m_busy = 1'b0;
      m_rr   = m_owner;
    end else if (wrote) begin
      m_cnt++;
      if (last[m_owner] || m_cnt == MAX_BURST) begin
        m_busy = 1'b0;
        m_rr   = m_owner;
      end
    end
  endfunction

  // ---------------- driver: one cycle, entered just after a falling edge ----------------
  task automatic step();
    logic              exp_wr;
    logic              exp_rd;
    logic [NREQ-1:0]   exp_gnt;
    logic [DATA_W-1:0] exp_wdata;
    din   = DW'($urandom);
    full  = (occ == DEPTH);
    empty = (occ == 0);
    #2;
    exp_gnt   = m_busy ? (NREQ'(1) << m_owner) : '0;
    exp_wr    = m_busy && req[m_owner] && !full;
    exp_rd    = rst && rd_req && !empty;
    exp_wdata = m_busy ? din[m_owner*DATA_W +: DATA_W] : '0;
    check("gnt",   32'(gnt),   32'(exp_gnt));
    check("busy",  32'(busy),  32'(m_busy));
    check("wr",    32'(wr),    32'(exp_wr));
    check("rd",    32'(rd),    32'(exp_rd));
    check("wdata", 32'(wdata), 32'(exp_wdata));
    // Scoreboard: the model queues each word it expects to be written.
    if (exp_wr) exp_q.push_back(din[m_owner*DATA_W +: DATA_W]);
    if (wr) begin
      wr_seen++;
      if (exp_q.size() > 0) check("sb_wdata", 32'(wdata), 32'(exp_q.pop_front()));
      else check("sb_spurious_wr", 32'(wr), 32'd0);
    end
    @(posedge clk);
    if (!rst) model_reset();
    else model_advance(exp_wr);
    occ = occ + int'(exp_wr) - int'(exp_rd);
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit reached;
    rst    = 1'b0;
    req    = 2'b11;
    last   = 2'b00;
    din    = '0;
    rd_req = 1'b0;
    occ    = 0;
    model_reset();

    // 1: reset held with requests pending, then released.
    step();
    step();
    rst = 1'b1;
    step();
    step();

    // 2: both requesting, reader draining: 4-word bursts alternating with idle gaps.
    rd_req = 1'b1;
    for (int n = 0; n < 12; n++) step();

    // Let the arbiter settle idle, then empty the fifo model.
    req = 2'b00;
    rd_req = 1'b0;
    step();
    step();
    occ = 0;

    // 3: requester 0 flags last on its second word; then requester 1 must win.
    req = 2'b01;
    wr_seen = 0;
    reached = 1'b0;
    for (int n = 0; n < 12; n++) begin
      last = (m_busy && m_cnt == 1) ? 2'b01 : 2'b00;
      step();
      if (!m_busy && wr_seen > 0) begin
        reached = 1'b1;
        break;
      end
    end
    check("t3_burst_end", 32'(reached), 32'd1);
    check("t3_wr_pulses", 32'(wr_seen), 32'd2);
    last = 2'b00;
    req  = 2'b11;
    step();
    step();
    check("t3_rr_next", 32'(gnt), 32'b10);
    req = 2'b00;
    step();
    step();

    // 4: fifo nearly full: write stalls with grant held, resumes after one read.
    occ = DEPTH - 2;
    req = 2'b01;
    for (int n = 0; n < 6; n++) step();
    check("t4_stalled_gnt", 32'(gnt), 32'b01);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    for (int n = 0; n < 4; n++) step();
    req = 2'b00;
    step();
    step();

    // 5: read gated by empty.
    occ = 0;
    rd_req = 1'b1;
    step();
    occ = 3;
    step();
    rd_req = 1'b0;

    // 6: reset mid-burst drops everything at once; requester 0 wins afterwards.
    occ = 0;
    req = 2'b10;
    reached = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (m_busy && m_cnt == 2) begin
        reached = 1'b1;
        break;
      end
      step();
    end
    check("t6_reach_cnt2", 32'(reached), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_gnt",  32'(gnt),  32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_wr",   32'(wr),   32'd0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    step();
    rst = 1'b1;
    req = 2'b11;
    step();
    step();
    check("t6_first_gnt", 32'(gnt), 32'b01);

    // Random traffic with sticky requests and occasional last flags.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      last   = ($urandom_range(0, 4) == 0) ? NREQ'($urandom_range(0, (1 << NREQ) - 1)) : '0;
      rd_req = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
